occ_gt_pattern_gen_chk: RTL and testbench
=========================================

Name: occ_gt_pattern_gen_chk

Overview:
Synthesizable link-test block for the OCC GT tiles (GTPE2/GTXE2), running in the usrclk domain.
- Generator: produces a comma-framed incrementing-counter pattern for the transceiver TX data and charisk inputs.
- Checker: locks onto the same pattern from the RX data and charisk outputs, and counts errors.
- Generalised over lane width, comma period, lock and unlock thresholds. Used for in-system BER tests and loopback self-test.

Parameters:
g_BYTES, 2, bytes per word; legal values 2 or 4.
g_COMMA_PERIOD_LOG2, 5, a comma is sent every 2**g_COMMA_PERIOD_LOG2 words.
g_LOCK_WORDS, 16, consecutive good data words required to enter LOCKED (range 1..255).
g_UNLOCK_ERRS, 4, consecutive bad words in LOCKED that return the checker to HUNT (range 1..255).

Ports:
clk_i  in  1  usrclk; all logic on the rising edge.
rst_n_i  in  1  asynchronous reset, active low.
en_i  in  1  generator enable; 0 = idle commas.
tx_data_o  out  8*g_BYTES  pattern word to the GT.
tx_charisk_o  out  g_BYTES  K-character flags for the TX word.
rx_valid_i  in  1  RX word qualifier.
rx_data_i  in  8*g_BYTES  RX word from the GT.
rx_charisk_i  in  g_BYTES  RX K-character flags.
rx_disperr_i  in  g_BYTES  RX disparity error flags.
rx_notintable_i  in  g_BYTES  RX not-in-table flags.
clr_i  in  1  synchronous clear of err_cnt_o.
locked_o  out  1  checker is in LOCKED.
err_o  out  1  one-cycle pulse per counted error.
err_cnt_o  out  32  saturating error count.

Behaviour:
Comma word definition:
- Byte g_BYTES-1 = 0xBC with K flag set.
- All other bytes = 0x95 with K flag clear.
- charisk = MSB only (2'b10 for 2 bytes, 4'b1000 for 4 bytes).

Generator:
- 8*g_BYTES-bit counter cnt; reset value 0.
- Outputs are registered; reset value of tx_data_o/tx_charisk_o is the comma word.
- en_i=1: output the word for cnt, then cnt <= cnt+1, wrapping mod 2**(8*g_BYTES).
  - word = comma if cnt[g_COMMA_PERIOD_LOG2-1:0]==0, else cnt with charisk 0.
- en_i=0: output the comma word; cnt is held.
- Latency: the en_i sample appears on the outputs 1 cycle later.

Checker word classification (only words with rx_valid_i=1 are evaluated; rx_valid_i=0 cycles are ignored in every state):
- comma: rx_data_i/rx_charisk_i equal the comma word.
- clean data: charisk==0, disperr==0 and notintable==0.
- Anything else is bad.

Checker state machine. States HUNT, SYNC, LOCKED; reset state HUNT. Internal exp register is 8*g_BYTES bits.
- HUNT:
  - Clean data D: exp <= D+1, match_cnt <= 1, go to SYNC. If g_LOCK_WORDS==1, go straight to LOCKED.
  - Anything else: stay in HUNT.
- SYNC and LOCKED, comma handling:
  - exp at a slot (low bits ==0): consume the comma, exp <= exp+1.
  - exp not at a slot: the comma is neutral idle; no change.
  - This rule makes generator pauses transparent to the checker.
- SYNC, non-comma words:
  - word==exp and clean: match_cnt++; when it reaches g_LOCK_WORDS, go to LOCKED.
  - Otherwise: go to HUNT; the error is not counted.
- LOCKED, non-comma words:
  - exp <= exp+1 unconditionally; no resync on a corrupted word.
  - Mismatch or bad word: err_o=1, err_cnt_o++ saturating at 0xFFFFFFFF, consec++.
  - consec reaching g_UNLOCK_ERRS: go to HUNT.
  - Good word: consec <= 0.

Outputs and boundary rules:
- locked_o, err_o and err_cnt_o are registered; reset values 0.
- err_o and locked_o follow the evaluated word by 1 cycle.
- exp wraps mod 2**(8*g_BYTES).
- clr_i in the same cycle as an error: clr_i wins, err_cnt_o=0, err_o still pulses.
- rst_n_i asserted mid-operation: everything returns to reset values immediately.

Optional Feature:
OCC_GT_PATCHK_ERR_INJ_EN:
- Defined: adds input err_inj_i (1 bit). A pulse arms a flag, and the next non-comma generated word has bit 0 inverted. The flag clears when that word is emitted. Pulses while armed are merged.
- Undefined: no port and no logic; generator output is always pristine.

Decomposition:
- Package occ_gt_pattern_pkg:
  - comma byte constants c_K28_5=8'hBC and c_D21_4=8'h95.
  - State enum t_chk_state {HUNT, SYNC, LOCKED}.
  - Function f_comma_word(bytes) returning data and charisk.
- One natural sub-module: occ_gt_pattern_chk (checker FSM plus counters).
- The generator stays inline in the top.

Test Plan:
1. g_BYTES=2, defaults, TX looped to RX, en_i=1 from reset -> first outputs {0xBC95, 2'b10}, then 0x0001. locked_o=1 within 32+16 words. err_cnt_o stays 0 for 10000 words.
2. Toggle en_i low for 7 cycles at cnt=0x0020 and again at cnt=0x0025 -> idle commas appear on TX; locked_o stays 1 and err_cnt_o stays 0.
3. With lock achieved, flip bit 3 of one RX data word -> err_o pulses once, err_cnt_o=1, locked_o stays 1.
4. Force 4 consecutive words to have disperr=2'b01 -> err_cnt_o=4 and locked_o drops 1 cycle after the 4th word; relock follows.
5. g_BYTES=4, preload-free run past wrap of the low 16 bits -> no errors; comma charisk is 4'b1000.
6. Assert clr_i with a simultaneous error, and test saturation via a forced err_cnt of 0xFFFFFFFE plus 3 errors -> err_cnt_o reads 0 and 0xFFFFFFFF respectively. With OCC_GT_PATCHK_ERR_INJ_EN defined, a single err_inj_i pulse -> exactly 1 counted error.

Source files
------------

// File: rtl/occ_gt_pattern_pkg.sv
// Shared constants, checker state encoding and comma-word builder for the
// OCC GT pattern generator/checker.
package occ_gt_pattern_pkg;

  localparam logic [7:0] c_K28_5 = 8'hBC;
  localparam logic [7:0] c_D21_4 = 8'h95;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } t_chk_state;

  // Sized for the widest lane; callers truncate to 8*bytes / bytes bits.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  charisk;
  } t_comma_word;

  function automatic t_comma_word f_comma_word(input int bytes);
    t_comma_word w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < bytes) begin
        w.data[8*i +: 8] = (i == bytes - 1) ? c_K28_5 : c_D21_4;
        if (i == bytes - 1) w.charisk[i] = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/occ_gt_pattern_chk.sv
// Pattern checker: HUNT/SYNC/LOCKED alignment to the incrementing-counter
// pattern, with a saturating error counter and single-cycle error pulse.
module occ_gt_pattern_chk
  import occ_gt_pattern_pkg::*;
#(
  parameter int g_BYTES             = 2,
  parameter int g_COMMA_PERIOD_LOG2 = 5,
  parameter int g_LOCK_WORDS        = 16,
  parameter int g_UNLOCK_ERRS       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_valid_i,
  input  logic [8*g_BYTES-1:0] rx_data_i,
  input  logic [g_BYTES-1:0]   rx_charisk_i,
  input  logic [g_BYTES-1:0]   rx_disperr_i,
  input  logic [g_BYTES-1:0]   rx_notintable_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [31:0]          err_cnt_o
);

  localparam int                 W             = 8 * g_BYTES;
  localparam t_comma_word        c_comma       = f_comma_word(g_BYTES);
  localparam logic [W-1:0]       c_comma_data  = W'(c_comma.data);
  localparam logic [g_BYTES-1:0] c_comma_k     = g_BYTES'(c_comma.charisk);
  localparam logic [7:0]         c_lock_words  = 8'(g_LOCK_WORDS);
  localparam logic [7:0]         c_unlock_errs = 8'(g_UNLOCK_ERRS);

  t_chk_state   state_q;
  logic [W-1:0] exp_q;
  logic [7:0]   match_q;
  logic [7:0]   consec_q;
  logic         err_q;
  logic [31:0]  err_cnt_q;

  logic is_comma, is_clean, is_good, exp_at_slot;

  assign is_comma    = (rx_data_i == c_comma_data) && (rx_charisk_i == c_comma_k);
  assign is_clean    = (rx_charisk_i == '0) && (rx_disperr_i == '0) && (rx_notintable_i == '0);
  assign is_good     = is_clean && (rx_data_i == exp_q);
  assign exp_at_slot = (exp_q[g_COMMA_PERIOD_LOG2-1:0] == '0);

  // NOTE: state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values of exp_q/match_q/consec_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      match_q   <= '0;
      consec_q  <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (rx_valid_i) begin
        if (state_q == HUNT) begin
          if (is_clean) begin
            exp_q    <= rx_data_i + 1'b1;
            match_q  <= 8'd1;
            consec_q <= '0;
            state_q  <= (g_LOCK_WORDS == 1) ? LOCKED : SYNC;
          end
        end else if (is_comma) begin
          // Commas off a slot are idle fill from a paused generator.
          if (exp_at_slot) exp_q <= exp_q + 1'b1;
        end else if (state_q == SYNC) begin
          if (is_good) begin
            exp_q   <= exp_q + 1'b1;
            match_q <= match_q + 8'd1;
            if (match_q + 8'd1 == c_lock_words) begin
              consec_q <= '0;
              state_q  <= LOCKED;
            end
          end else begin
            state_q <= HUNT;
          end
        end else if (state_q == LOCKED) begin
          exp_q <= exp_q + 1'b1;
          if (is_good) begin
            consec_q <= '0;
          end else begin
            err_q    <= 1'b1;
            consec_q <= consec_q + 8'd1;
            if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
            if (consec_q + 8'd1 == c_unlock_errs) state_q <= HUNT;
          end
        end else begin
          state_q <= HUNT;
        end
      end
      if (clr_i) err_cnt_q <= '0;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/occ_gt_pattern_gen_chk.sv
// OCC GT link-test top: inline comma-framed counter generator plus checker.
// Optional TX error injection is enabled by defining OCC_GT_PATCHK_ERR_INJ_EN.
module occ_gt_pattern_gen_chk
  import occ_gt_pattern_pkg::*;
#(
  parameter int g_BYTES             = 2,
  parameter int g_COMMA_PERIOD_LOG2 = 5,
  parameter int g_LOCK_WORDS        = 16,
  parameter int g_UNLOCK_ERRS       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
`ifdef OCC_GT_PATCHK_ERR_INJ_EN
  input  logic                 err_inj_i,
`endif
  output logic [8*g_BYTES-1:0] tx_data_o,
  output logic [g_BYTES-1:0]   tx_charisk_o,
  input  logic                 rx_valid_i,
  input  logic [8*g_BYTES-1:0] rx_data_i,
  input  logic [g_BYTES-1:0]   rx_charisk_i,
  input  logic [g_BYTES-1:0]   rx_disperr_i,
  input  logic [g_BYTES-1:0]   rx_notintable_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [31:0]          err_cnt_o
);

  localparam int                 W            = 8 * g_BYTES;
  localparam t_comma_word        c_comma      = f_comma_word(g_BYTES);
  localparam logic [W-1:0]       c_comma_data = W'(c_comma.data);
  localparam logic [g_BYTES-1:0] c_comma_k    = g_BYTES'(c_comma.charisk);

  logic [W-1:0] cnt_q;
  logic         slot;
  logic [W-1:0] inj_mask;

  assign slot = (cnt_q[g_COMMA_PERIOD_LOG2-1:0] == '0);

`ifdef OCC_GT_PATCHK_ERR_INJ_EN
  logic armed_q;

  // Once armed, further pulses are absorbed until the corrupted word leaves.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) armed_q <= 1'b0;
    else if (armed_q) armed_q <= !(en_i && !slot);
    else armed_q <= err_inj_i;
  end

  assign inj_mask = {{(W-1){1'b0}}, armed_q};
`else
  assign inj_mask = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q        <= '0;
      tx_data_o    <= c_comma_data;
      tx_charisk_o <= c_comma_k;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (slot) begin
        tx_data_o    <= c_comma_data;
        tx_charisk_o <= c_comma_k;
      end else begin
        tx_data_o    <= cnt_q ^ inj_mask;
        tx_charisk_o <= '0;
      end
    end else begin
      tx_data_o    <= c_comma_data;
      tx_charisk_o <= c_comma_k;
    end
  end

  occ_gt_pattern_chk #(
    .g_BYTES            (g_BYTES),
    .g_COMMA_PERIOD_LOG2(g_COMMA_PERIOD_LOG2),
    .g_LOCK_WORDS       (g_LOCK_WORDS),
    .g_UNLOCK_ERRS      (g_UNLOCK_ERRS)
  ) u_chk (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .rx_valid_i     (rx_valid_i),
    .rx_data_i      (rx_data_i),
    .rx_charisk_i   (rx_charisk_i),
    .rx_disperr_i   (rx_disperr_i),
    .rx_notintable_i(rx_notintable_i),
    .clr_i          (clr_i),
    .locked_o       (locked_o),
    .err_o          (err_o),
    .err_cnt_o      (err_cnt_o)
  );

endmodule

// File: tb/tb_occ_gt_pattern_gen_chk.sv
// Directed loopback bench: a 2-byte instance under directed corruption and a
// free-running 4-byte instance that must cross the 16-bit counter wrap cleanly.
module tb_occ_gt_pattern_gen_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst4_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        inj = 1'b0;
  logic        valid = 1'b1;
  logic [15:0] flip = '0;
  logic [1:0]  disp = '0;
  logic [1:0]  nit = '0;

  logic [15:0] tx_data, rx_data;
  logic [1:0]  tx_k;
  logic        locked, err;
  logic [31:0] err_cnt;

  logic [31:0] tx4;
  logic [3:0]  k4;
  logic        locked4, err4;
  logic [31:0] err_cnt4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_data = tx_data ^ flip;

  occ_gt_pattern_gen_chk #(.g_BYTES(2)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .en_i           (en),
`ifdef OCC_GT_PATCHK_ERR_INJ_EN
    .err_inj_i      (inj),
`endif
    .tx_data_o      (tx_data),
    .tx_charisk_o   (tx_k),
    .rx_valid_i     (valid),
    .rx_data_i      (rx_data),
    .rx_charisk_i   (tx_k),
    .rx_disperr_i   (disp),
    .rx_notintable_i(nit),
    .clr_i          (clr),
    .locked_o       (locked),
    .err_o          (err),
    .err_cnt_o      (err_cnt)
  );

  occ_gt_pattern_gen_chk #(.g_BYTES(4)) dut4 (
    .clk_i          (clk),
    .rst_n_i        (rst4_n),
    .en_i           (1'b1),
`ifdef OCC_GT_PATCHK_ERR_INJ_EN
    .err_inj_i      (1'b0),
`endif
    .tx_data_o      (tx4),
    .tx_charisk_o   (k4),
    .rx_valid_i     (1'b1),
    .rx_data_i      (tx4),
    .rx_charisk_i   (k4),
    .rx_disperr_i   (4'b0000),
    .rx_notintable_i(4'b0000),
    .clr_i          (1'b0),
    .locked_o       (locked4),
    .err_o          (err4),
    .err_cnt_o      (err_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits at negedges until the TX word equals v (bounded).
  task automatic wait_word(input string tag, input logic [15:0] v);
    int n = 0;
    while (!(tx_data === v && tx_k === 2'b00) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_data === v && tx_k === 2'b00), 32'd1);
  endtask

  // Waits until the TX word is data with the given low 5 bits (bounded).
  task automatic wait_low(input string tag, input logic [4:0] v);
    int n = 0;
    while (!(tx_data[4:0] === v && tx_k === 2'b00) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_data[4:0] === v && tx_k === 2'b00), 32'd1);
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int n = 0;
    while (locked !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h0000_BC95);
    check("rst_tx_k", 32'(tx_k), 32'h2);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    check("rst4_tx_data", tx4, 32'hBC95_9595);
    check("rst4_tx_k", 32'(k4), 32'h8);

    rst_n  = 1'b1;
    rst4_n = 1'b1;
    @(negedge clk);
    check("first_word", 32'(tx_data), 32'h0000_BC95);
    check("first_k", 32'(tx_k), 32'h2);
    @(negedge clk);
    check("second_word", 32'(tx_data), 32'h0000_0001);
    check("second_k", 32'(tx_k), 32'h0);
    wait_lock("lock_in_48", 46);

    // Generator pauses on a comma slot and mid-frame.
    wait_word("reach_001f", 16'h001F);
    en = 1'b0;
    repeat (7) @(negedge clk);
    check("idle_comma1", 32'(tx_data), 32'h0000_BC95);
    en = 1'b1;
    @(negedge clk);
    check("resume1_comma", 32'(tx_data), 32'h0000_BC95);
    @(negedge clk);
    check("resume1_word", 32'(tx_data), 32'h0000_0021);
    wait_word("reach_0024", 16'h0024);
    en = 1'b0;
    repeat (7) @(negedge clk);
    check("idle_comma2", 32'(tx_data), 32'h0000_BC95);
    check("idle_comma2_k", 32'(tx_k), 32'h2);
    en = 1'b1;
    @(negedge clk);
    check("resume2_word", 32'(tx_data), 32'h0000_0025);
    @(negedge clk);
    check("pause_locked", 32'(locked), 32'd1);
    check("pause_err_cnt", err_cnt, 32'd0);

    repeat (10000) @(negedge clk);
    check("soak_err_cnt", err_cnt, 32'd0);
    check("soak_locked", 32'(locked), 32'd1);

    // Single bit-3 flip.
    wait_low("flip_align", 5'd3);
    flip = 16'h0008;
    @(negedge clk);
    flip = '0;
    check("flip_err", 32'(err), 32'd1);
    check("flip_err_cnt", err_cnt, 32'd1);
    check("flip_locked", 32'(locked), 32'd1);
    @(negedge clk);
    check("flip_err_once", 32'(err), 32'd0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_alone", err_cnt, 32'd0);

    // Four consecutive disparity errors unlock the checker.
    wait_low("disp_align", 5'd5);
    disp = 2'b01;
    repeat (3) @(negedge clk);
    check("disp3_locked", 32'(locked), 32'd1);
    check("disp3_err_cnt", err_cnt, 32'd3);
    @(negedge clk);
    disp = '0;
    check("disp4_err_cnt", err_cnt, 32'd4);
    check("disp4_unlocked", 32'(locked), 32'd0);
    wait_lock("relock", 60);

    // Clear coinciding with an error.
    wait_low("clr_align", 5'd3);
    flip = 16'h0008;
    clr  = 1'b1;
    @(negedge clk);
    flip = '0;
    clr  = 1'b0;
    check("clr_err_pulse", 32'(err), 32'd1);
    check("clr_wins", err_cnt, 32'd0);

    // Saturation from a preset count.
    wait_low("sat_align", 5'd3);
    force dut.u_chk.err_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_chk.err_cnt_q;
    flip = 16'h0008;
    @(negedge clk);
    check("sat_reach", err_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    flip = '0;
    check("sat_hold", err_cnt, 32'hFFFF_FFFF);
    check("sat_locked", 32'(locked), 32'd1);

`ifdef OCC_GT_PATCHK_ERR_INJ_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    repeat (80) @(negedge clk);
    check("inj_err_cnt", err_cnt, 32'd1);
    check("inj_locked", 32'(locked), 32'd1);
`endif

    // Asynchronous reset mid-operation.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err_cnt", err_cnt, 32'd0);
    check("mid_rst_tx", 32'(tx_data), 32'h0000_BC95);
    @(negedge clk);
    rst_n = 1'b1;

    // 4-byte instance: run past the wrap of the low 16 counter bits.
    while (cyc < 66000) @(negedge clk);
    while (k4 !== 4'b0000 && cyc < 66100) @(negedge clk);
    check("w4_data_word", 32'(k4), 32'h0);
    check("w4_past_wrap", 32'(tx4[31:16]), 32'h0000_0001);
    check("w4_err_cnt", err_cnt4, 32'd0);
    check("w4_locked", 32'(locked4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
